// File: rtl/axi_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_pkg
//  Purpose  : Shared AXI response codes, FSM state types and the response
//             priority helper for the AXI SRAM slave.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // A decode error says more about the transfer than a slave error, so it wins.
    function automatic logic [1:0] pick_resp(input logic dec_err, input logic slv_err);
        logic [1:0] resp;
        resp = RESP_OKAY;
        if (dec_err) begin
            resp = RESP_DECERR;
        end else if (slv_err) begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

endpackage : axi_sram_pkg
`default_nettype wire

// File: rtl/axi_sram_bytemem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_bytemem
//  Purpose  : DEPTH x DATA_W storage with per-byte write enables, one write
//             port and one registered read port. Contents are never reset.
//  Ports    : wb_clk_i  - clock
//             we        - per-byte write enable
//             waddr     - write word index
//             wdata     - write data
//             re        - read enable; rdata only updates when asserted
//             raddr     - read word index
//             rdata     - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_bytemem #(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              wb_clk_i,
    input  logic [BYTES-1:0]  we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read and write in the same block with non-blocking assignment: a
    // same-word read in the write cycle returns the old contents.
    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) begin
                r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        // rdata holds while re is low so a stalled read beat stays stable
        // even if the same word is written meanwhile.
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule : axi_sram_bytemem
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Purpose  : AXI4 slave scratch RAM. INCR bursts up to 256 beats, word
//             addressed with byte strobes, independent read and write FSMs.
//  Ports    : wb_clk_i / wb_rst_i       - clock, async active-high reset
//             s_axi_aw* / s_axi_w*      - write address and data channels
//             s_axi_b*                  - write response channel
//             s_axi_ar* / s_axi_r*      - read address and data channels
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast
);

    localparam int BYTES   = DATA_W / 8;
    localparam int OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WADDR_W = ADDR_W - OFF_W;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WADDR_W-1:0] C_DEPTH_W = WADDR_W'(DEPTH);

    // ---------------------------------------------------------------- write
    wstate_t              r_wstate;
    logic [WADDR_W-1:0]   r_waddr;
    logic [7:0]           r_wlen;
    logic [8:0]           r_wcnt;
    logic                 r_wdec;
    logic                 r_wslv;

    logic                 w_w_hs;
    logic                 w_w_oor;
    logic                 w_w_extra;
    logic                 w_w_short;
    logic [BYTES-1:0]     w_mem_we;
    logic [1:0]           w_bresp_next;
    logic [WADDR_W-1:0]   w_aw_word;

    assign w_aw_word = s_axi_awaddr[ADDR_W-1:OFF_W];
    assign w_w_hs    = s_axi_wvalid && s_axi_wready;
    assign w_w_oor   = (r_waddr >= C_DEPTH_W);
    // Nine-bit beat count so a 256-beat burst plus overrun stays distinguishable.
    assign w_w_extra = (r_wcnt > {1'b0, r_wlen});
    assign w_w_short = s_axi_wlast && (r_wcnt < {1'b0, r_wlen});
    assign w_mem_we  = (w_w_hs && !w_w_oor && !w_w_extra) ? s_axi_wstrb : '0;
    // Fold the current beat's errors in so the last beat counts too.
    assign w_bresp_next = pick_resp(r_wdec || w_w_oor, r_wslv || w_w_extra || w_w_short);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wstate      <= W_IDLE;
            r_waddr       <= '0;
            r_wlen        <= '0;
            r_wcnt        <= '0;
            r_wdec        <= 1'b0;
            r_wslv        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        r_waddr       <= w_aw_word;
                        r_wlen        <= s_axi_awlen;
                        r_wcnt        <= '0;
                        r_wdec        <= 1'b0;
                        r_wslv        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        r_wstate      <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= r_waddr + 1'b1;
                        if (r_wcnt != '1) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                        if (w_w_oor) begin
                            r_wdec <= 1'b1;
                        end
                        if (w_w_extra || w_w_short) begin
                            r_wslv <= 1'b1;
                        end
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= w_bresp_next;
                            r_wstate     <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        r_wstate      <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------- read
    rstate_t              r_rstate;
    logic [WADDR_W-1:0]   r_raddr;
    logic [7:0]           r_rlen;
    logic [7:0]           r_rcnt;
    logic                 r_roor;

    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_r_more;
    logic [WADDR_W-1:0]   w_ar_word;
    logic [WADDR_W-1:0]   w_r_next;
    logic                 w_mem_re;
    logic [IDX_W-1:0]     w_mem_raddr;
    logic [DATA_W-1:0]    w_mem_rdata;

    assign w_ar_word = s_axi_araddr[ADDR_W-1:OFF_W];
    assign w_r_next  = r_raddr + 1'b1;
    assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
    assign w_r_hs    = s_axi_rvalid && s_axi_rready;
    assign w_r_more  = (r_rcnt != r_rlen);

    // The RAM is read one cycle ahead of presentation: on the AR handshake for
    // beat 0, and on each R handshake for the following beat, so beats flow
    // back to back without a bubble.
    assign w_mem_re    = w_ar_hs || (w_r_hs && w_r_more);
    assign w_mem_raddr = (r_rstate == R_IDLE) ? w_ar_word[IDX_W-1:0] : w_r_next[IDX_W-1:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rstate      <= R_IDLE;
            r_raddr       <= '0;
            r_rlen        <= '0;
            r_rcnt        <= '0;
            r_roor        <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr       <= w_ar_word;
                        r_rlen        <= s_axi_arlen;
                        r_rcnt        <= '0;
                        r_roor        <= (w_ar_word >= C_DEPTH_W);
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        r_rstate      <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (w_r_more) begin
                            r_raddr     <= w_r_next;
                            r_rcnt      <= r_rcnt + 1'b1;
                            r_roor      <= (w_r_next >= C_DEPTH_W);
                            s_axi_rlast <= ((r_rcnt + 1'b1) == r_rlen);
                        end else begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_rstate      <= R_IDLE;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Gating on rvalid keeps rdata/rresp at zero in reset and between bursts,
    // since the RAM output register itself is never reset.
    assign s_axi_rdata = (s_axi_rvalid && !r_roor) ? w_mem_rdata : '0;
    assign s_axi_rresp = (s_axi_rvalid && r_roor) ? RESP_DECERR : RESP_OKAY;

    axi_sram_bytemem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .wb_clk_i (wb_clk_i),
        .we       (w_mem_we),
        .waddr    (r_waddr[IDX_W-1:0]),
        .wdata    (s_axi_wdata),
        .re       (w_mem_re),
        .raddr    (w_mem_raddr),
        .rdata    (w_mem_rdata)
    );

    // Sub-word address bits carry no information for full-width beats.
    logic w_unused;
    assign w_unused = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

endmodule : axi_sram_slave
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_slave
//  Purpose  : Directed self-checking bench for axi_sram_slave.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    logic        clk;
    logic        rst;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int vectors    = 0;
    int miscompares = 0;

    axi_sram_slave #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (256)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic aw_req(input logic [31:0] addr, input logic [7:0] len);
        int n;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = len;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("aw_timeout", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        n = 0;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("w_timeout", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_resp(input string tag, input logic [1:0] exp, input int hold);
        int n;
        bready = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("b_timeout", 32'(bvalid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("bvalid_held", 32'({bvalid, bresp}), 32'({1'b1, exp}));
            @(negedge clk);
        end
        bready = 1'b1;
        chk(tag, 32'({bvalid, bresp}), 32'({1'b1, exp}));
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", 32'({bvalid, awready}), 32'b01);
    endtask

    // Leaves the bench at the falling edge where beat 0 must already be shown.
    task automatic ar_req(input logic [31:0] addr, input logic [7:0] len);
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = len;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ar_timeout", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic rbeat(input string tag, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input logic exp_last);
        rready = 1'b1;
        chk({tag, "_ctl"}, 32'({rvalid, rlast, rresp}), 32'({1'b1, exp_last, exp_resp}));
        chk({tag, "_data"}, rdata, exp_data);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awlen = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        bready = 0; arvalid = 0; araddr = 0; arlen = 0; rready = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_ctl", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast}), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'({awready, arready, wready}), 32'b110);

        // 1: single-beat write and read back
        aw_req(32'h10, 8'd0);
        wbeat(32'hDEADBEEF, 4'hF, 1'b1);
        b_resp("t1_bresp", 2'b00, 0);
        ar_req(32'h10, 8'd0);
        rbeat("t1_r0", 32'hDEADBEEF, 2'b00, 1'b1);
        chk("t1_r_end", 32'({rvalid, rlast}), 32'b00);
        rready = 1'b0;

        // 2: four-beat burst
        aw_req(32'h20, 8'd3);
        wbeat(32'hA5A5A5A5, 4'hF, 1'b0);
        wbeat(32'hA5A5A5A6, 4'hF, 1'b0);
        wbeat(32'hA5A5A5A7, 4'hF, 1'b0);
        wbeat(32'hA5A5A5A8, 4'hF, 1'b1);
        b_resp("t2_bresp", 2'b00, 0);
        ar_req(32'h20, 8'd3);
        rbeat("t2_r0", 32'hA5A5A5A5, 2'b00, 1'b0);
        rbeat("t2_r1", 32'hA5A5A5A6, 2'b00, 1'b0);
        rbeat("t2_r2", 32'hA5A5A5A7, 2'b00, 1'b0);
        rbeat("t2_r3", 32'hA5A5A5A8, 2'b00, 1'b1);
        chk("t2_r_end", 32'({rvalid, rlast, arready}), 32'b001);
        rready = 1'b0;

        // 3: byte strobes
        aw_req(32'h40, 8'd0);
        wbeat(32'hFFFFFFFF, 4'hF, 1'b1);
        b_resp("t3a_bresp", 2'b00, 0);
        aw_req(32'h40, 8'd0);
        wbeat(32'h11223344, 4'b0101, 1'b1);
        b_resp("t3b_bresp", 2'b00, 0);
        ar_req(32'h40, 8'd0);
        rbeat("t3_r0", 32'hFF22FF44, 2'b00, 1'b1);
        rready = 1'b0;

        // 4a: read stall mid-burst holds beat stable
        ar_req(32'h20, 8'd3);
        rbeat("t4_r0", 32'hA5A5A5A5, 2'b00, 1'b0);
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_ctl", 32'({rvalid, rlast, rresp}), 32'b1000);
            chk("t4_stall_data", rdata, 32'hA5A5A5A6);
            @(negedge clk);
        end
        rbeat("t4_r1", 32'hA5A5A5A6, 2'b00, 1'b0);
        rbeat("t4_r2", 32'hA5A5A5A7, 2'b00, 1'b0);
        rbeat("t4_r3", 32'hA5A5A5A8, 2'b00, 1'b1);
        rready = 1'b0;

        // 4b: early wlast on beat 1 of a len-3 burst
        aw_req(32'h60, 8'd3);
        wbeat(32'h00000001, 4'hF, 1'b0);
        wbeat(32'h00000002, 4'hF, 1'b1);
        b_resp("t4_bresp_short", 2'b10, 0);

        // 5: last word in range, then one beyond; bready held off 5 cycles
        aw_req(32'h3FC, 8'd0);
        wbeat(32'h0BADF00D, 4'hF, 1'b1);
        b_resp("t5_bresp_held", 2'b00, 5);
        ar_req(32'h3FC, 8'd1);
        rbeat("t5_r0", 32'h0BADF00D, 2'b00, 1'b0);
        rbeat("t5_r1", 32'h00000000, 2'b11, 1'b1);
        rready = 1'b0;
        aw_req(32'h400, 8'd0);
        wbeat(32'hCAFEF00D, 4'hF, 1'b1);
        b_resp("t5_bresp_decerr", 2'b11, 0);

        // 6: asynchronous reset in the middle of a write burst
        aw_req(32'h80, 8'd3);
        wbeat(32'h00000011, 4'hF, 1'b0);
        wbeat(32'h00000022, 4'hF, 1'b0);
        wvalid = 1'b1; wdata = 32'h00000033; wstrb = 4'hF;
        #2 rst = 1'b1;
        #1 chk("t6_async_ctl", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast}), 32'd0);
        chk("t6_async_rdata", rdata, 32'd0);
        wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_again", 32'({awready, arready, wready, bvalid}), 32'b1100);
        ar_req(32'h10, 8'd0);
        rbeat("t6_keep", 32'hDEADBEEF, 2'b00, 1'b1);
        rready = 1'b0;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_axi_sram_slave
`default_nettype wire
